// File: rtl/controle_elevador_if.sv
// Elevator controller signal bundle: floor calls in, car position/status out.
// Latency: none, wires only.
// Backpressure: none; calls are level-sampled and latched by the controller.
//   chamada      : floor call requests, bit i = floor i (driven by master)
//   andar        : current floor 0..3
//   B1, B0       : registered direction/state code for the display decoder
//   porta_aberta : door open
//   pendentes    : registered outstanding requests
interface controle_elevador_if;
   logic [3:0] chamada;
   logic [1:0] andar;
   logic       B0;
   logic       B1;
   logic       porta_aberta;
   logic [3:0] pendentes;

   modport master (
      output chamada,
      input  andar, B0, B1, porta_aberta, pendentes
   );

   modport slave (
      input  chamada,
      output andar, B0, B1, porta_aberta, pendentes
   );
endinterface

// File: rtl/controle_elevador.sv
// Four-floor elevator controller: latches calls, moves the car, opens the door.
// Latency: a call is acted on at the next rising edge; floor steps every T_ANDAR edges.
// Backpressure: none; calls are never refused, they accumulate in pendentes.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of controle_elevador_if (chamada in; andar, B1/B0,
//              porta_aberta, pendentes out, all registered)
module controle_elevador #(
   parameter int T_ANDAR = 4,
   parameter int T_PORTA = 3
) (
   input logic                clk,
   input logic                rst,
   controle_elevador_if.slave bus
);

   // State encoding doubles as the display code {B1,B0}.
   typedef enum logic [1:0] {
      PARADO   = 2'b00,
      SUBINDO  = 2'b01,
      DESCENDO = 2'b10,
      PORTA    = 2'b11
   } estado_t;

   localparam int CMAX = (T_ANDAR > T_PORTA) ? T_ANDAR : T_PORTA;
   localparam int CW   = $clog2(CMAX);
   // Counters load N-1 and the transition happens on the edge where they read 0,
   // giving exactly N edges in the state.
   localparam logic [CW-1:0] CARGA_ANDAR = CW'(T_ANDAR - 1);
   localparam logic [CW-1:0] CARGA_PORTA = CW'(T_PORTA - 1);

   estado_t       estado_q, estado_d;
   logic [1:0]    andar_q, andar_d;
   logic [3:0]    pend_q, pend_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ult_q, ult_d;      // last travel direction, 1 = up
   logic          porta_q, porta_d;

   logic [3:0]    req;
   logic [1:0]    andar_prox;
   logic          acima, abaixo;
   logic          ir_sobe, ir_desce, ir_porta;

   // A call arriving this very cycle counts as much as a latched one.
   assign req = pend_q | bus.chamada;

   function automatic logic tem_acima(input logic [3:0] r, input logic [1:0] f);
      logic res;
      res = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > int'(f)) res = res | r[i];
      end
      return res;
   endfunction

   function automatic logic tem_abaixo(input logic [3:0] r, input logic [1:0] f);
      logic res;
      res = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i < int'(f)) res = res | r[i];
      end
      return res;
   endfunction

   assign acima  = tem_acima(req, andar_q);
   assign abaixo = tem_abaixo(req, andar_q);

   always_comb begin
      estado_d   = estado_q;
      andar_d    = andar_q;
      cnt_d      = cnt_q;
      ult_d      = ult_q;
      pend_d     = pend_q | bus.chamada;
      andar_prox = andar_q;
      ir_sobe    = 1'b0;
      ir_desce   = 1'b0;
      ir_porta   = 1'b0;

      case (estado_q)
         PARADO: begin
            if (req[andar_q]) begin
               ir_porta = 1'b1;
            end else if (acima && abaixo) begin
               ir_sobe  = ult_q;
               ir_desce = !ult_q;
            end else if (acima) begin
               ir_sobe = 1'b1;
            end else if (abaixo) begin
               ir_desce = 1'b1;
            end
         end

         SUBINDO, DESCENDO: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               // Floor-step edge: every decision looks at the floor being entered.
               andar_prox = (estado_q == SUBINDO) ? andar_q + 2'd1 : andar_q - 2'd1;
               andar_d    = andar_prox;
               if (req[andar_prox]) begin
                  ir_porta = 1'b1;
               end else if ((estado_q == SUBINDO) ? tem_acima(req, andar_prox)
                                                  : tem_abaixo(req, andar_prox)) begin
                  cnt_d = CARGA_ANDAR;
               end else begin
                  estado_d = PARADO;
                  cnt_d    = '0;
               end
            end
         end

         PORTA: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (ult_q ? acima : abaixo) begin
               ir_sobe  = ult_q;
               ir_desce = !ult_q;
            end else if (ult_q ? abaixo : acima) begin
               ir_sobe  = !ult_q;
               ir_desce = ult_q;
            end else begin
               estado_d = PARADO;
            end
         end

         default: estado_d = PARADO;
      endcase

      if (ir_porta) begin
         estado_d = PORTA;
         cnt_d    = CARGA_PORTA;
      end else if (ir_sobe) begin
         estado_d = SUBINDO;
         cnt_d    = CARGA_ANDAR;
         ult_d    = 1'b1;
      end else if (ir_desce) begin
         estado_d = DESCENDO;
         cnt_d    = CARGA_ANDAR;
         ult_d    = 1'b0;
      end

      // The floor with the door open is served: calls to it are absorbed
      // without extending the door time.
      if (estado_q == PORTA) pend_d[andar_q] = 1'b0;
      if (estado_d == PORTA) pend_d[andar_d] = 1'b0;

      porta_d = (estado_d == PORTA);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q <= PARADO;
         andar_q  <= 2'd0;
         pend_q   <= 4'b0000;
         cnt_q    <= '0;
         ult_q    <= 1'b1;
         porta_q  <= 1'b0;
      end else begin
         estado_q <= estado_d;
         andar_q  <= andar_d;
         pend_q   <= pend_d;
         cnt_q    <= cnt_d;
         ult_q    <= ult_d;
         porta_q  <= porta_d;
      end
   end

   assign bus.andar        = andar_q;
   assign bus.B1           = estado_q[1];
   assign bus.B0           = estado_q[0];
   assign bus.porta_aberta = porta_q;
   assign bus.pendentes    = pend_q;

endmodule

// File: tb/tb_controle_elevador.sv
// Bench for controle_elevador: directed call sequences, expected per-cycle outputs
// queued by the stimulus and checked by an independent monitor after each edge.
module tb_controle_elevador;

   typedef struct packed {
      logic [1:0] code;
      logic [1:0] andar;
      logic       porta;
      logic [3:0] pend;
   } obs_t;

   localparam logic [1:0] PAR = 2'b00;
   localparam logic [1:0] SUB = 2'b01;
   localparam logic [1:0] DES = 2'b10;
   localparam logic [1:0] POR = 2'b11;

   logic clk;
   logic rst;

   controle_elevador_if bus ();

   controle_elevador #(
      .T_ANDAR(4),
      .T_PORTA(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   obs_t  exp_q[$];
   string tag_q[$];
   string cur_tag;
   int    total;
   int    bad;

   function automatic obs_t sample();
      obs_t o;
      o.code  = {bus.B1, bus.B0};
      o.andar = bus.andar;
      o.porta = bus.porta_aberta;
      o.pend  = bus.pendentes;
      return o;
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got code=%b andar=%0d porta=%b pend=%b, want code=%b andar=%0d porta=%b pend=%b",
                  name, act.code, act.andar, act.porta, act.pend,
                  want.code, want.andar, want.porta, want.pend);
      end
   endtask

   // Queue n identical expected observations, one per coming clock edge.
   task automatic expect_n(input int n, input logic [1:0] code, input logic [1:0] a,
                           input logic p, input logic [3:0] pe);
      obs_t e;
      e.code  = code;
      e.andar = a;
      e.porta = p;
      e.pend  = pe;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(e);
         tag_q.push_back(cur_tag);
      end
   endtask

   // Called at a falling edge: drive c0 for one cycle, optionally pulse c2 at
   // falling edge number p2, and return at falling edge number k.
   task automatic run(input int k, input logic [3:0] c0, input int p2, input logic [3:0] c2);
      bus.chamada = c0;
      for (int n = 1; n <= k; n++) begin
         @(negedge clk);
         bus.chamada = (n == p2) ? c2 : 4'b0000;
      end
   endtask

   // Monitor: one comparison per edge while expectations are outstanding.
   initial begin
      obs_t  e;
      string t;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, sample(), e);
         end
      end
   end

   initial begin
      obs_t zero;
      total = 0;
      bad   = 0;
      zero  = '0;
      rst   = 1'b1;
      bus.chamada = 4'b0000;
      repeat (3) @(negedge clk);
      check("reset_state", sample(), zero);
      rst = 1'b0;

      cur_tag = "idle";
      expect_n(2, PAR, 2'd0, 1'b0, 4'b0000);
      run(2, 4'b0000, 0, 4'b0000);

      // Call to the current floor: door opens at once for three cycles.
      cur_tag = "local_call";
      expect_n(3, POR, 2'd0, 1'b1, 4'b0000);
      expect_n(1, PAR, 2'd0, 1'b0, 4'b0000);
      run(4, 4'b0001, 0, 4'b0000);

      // 0 -> 3 with steps every four edges.
      cur_tag = "full_travel";
      expect_n(4, SUB, 2'd0, 1'b0, 4'b1000);
      expect_n(4, SUB, 2'd1, 1'b0, 4'b1000);
      expect_n(4, SUB, 2'd2, 1'b0, 4'b1000);
      expect_n(3, POR, 2'd3, 1'b1, 4'b0000);
      expect_n(1, PAR, 2'd3, 1'b0, 4'b0000);
      run(16, 4'b1000, 0, 4'b0000);

      cur_tag = "down_to_1";
      expect_n(4, DES, 2'd3, 1'b0, 4'b0010);
      expect_n(4, DES, 2'd2, 1'b0, 4'b0010);
      expect_n(3, POR, 2'd1, 1'b1, 4'b0000);
      expect_n(1, PAR, 2'd1, 1'b0, 4'b0000);
      run(12, 4'b0010, 0, 4'b0000);

      // Going up from 1 to 3 while floor 0 is called: finish upward first.
      cur_tag = "dir_pref";
      expect_n(2, SUB, 2'd1, 1'b0, 4'b1000);
      expect_n(2, SUB, 2'd1, 1'b0, 4'b1001);
      expect_n(4, SUB, 2'd2, 1'b0, 4'b1001);
      expect_n(3, POR, 2'd3, 1'b1, 4'b0001);
      expect_n(4, DES, 2'd3, 1'b0, 4'b0001);
      expect_n(4, DES, 2'd2, 1'b0, 4'b0001);
      expect_n(4, DES, 2'd1, 1'b0, 4'b0001);
      expect_n(3, POR, 2'd0, 1'b1, 4'b0000);
      expect_n(1, PAR, 2'd0, 1'b0, 4'b0000);
      run(27, 4'b1000, 2, 4'b0001);

      // Call to floor 2 while moving 0 -> 3: intermediate stop, then continue.
      cur_tag = "mid_stop";
      expect_n(2, SUB, 2'd0, 1'b0, 4'b1000);
      expect_n(2, SUB, 2'd0, 1'b0, 4'b1100);
      expect_n(4, SUB, 2'd1, 1'b0, 4'b1100);
      expect_n(3, POR, 2'd2, 1'b1, 4'b1000);
      expect_n(4, SUB, 2'd2, 1'b0, 4'b1000);
      expect_n(3, POR, 2'd3, 1'b1, 4'b0000);
      expect_n(1, PAR, 2'd3, 1'b0, 4'b0000);
      run(19, 4'b1000, 2, 4'b0100);

      // Door open at 2, same floor called again: no extension, no latch.
      cur_tag = "absorbed";
      expect_n(4, DES, 2'd3, 1'b0, 4'b0100);
      expect_n(3, POR, 2'd2, 1'b1, 4'b0000);
      expect_n(1, PAR, 2'd2, 1'b0, 4'b0000);
      run(8, 4'b0100, 5, 4'b0100);

      // Reset in the middle of an upward trip.
      cur_tag = "pre_reset";
      expect_n(3, SUB, 2'd2, 1'b0, 4'b1000);
      run(3, 4'b1000, 0, 4'b0000);
      rst = 1'b1;
      #1;
      check("async_reset", sample(), zero);
      cur_tag = "reset_held";
      expect_n(1, PAR, 2'd0, 1'b0, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      cur_tag = "after_reset";
      expect_n(3, POR, 2'd0, 1'b1, 4'b0000);
      expect_n(1, PAR, 2'd0, 1'b0, 4'b0000);
      run(4, 4'b0001, 0, 4'b0000);

      @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_expectations: got %0d pending, want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
